// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state type and arithmetic helpers for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;

  localparam logic [OPW-1:0] MDU_NONE  = 4'd0;
  localparam logic [OPW-1:0] MDU_MULT  = 4'd1;
  localparam logic [OPW-1:0] MDU_MULTU = 4'd2;
  localparam logic [OPW-1:0] MDU_DIV   = 4'd3;
  localparam logic [OPW-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OPW-1:0] MDU_MTHI  = 4'd5;
  localparam logic [OPW-1:0] MDU_MTLO  = 4'd6;
  localparam logic [OPW-1:0] MDU_MFHI  = 4'd7;
  localparam logic [OPW-1:0] MDU_MFLO  = 4'd8;
  localparam logic [OPW-1:0] MDU_MADD  = 4'd9;
  localparam logic [OPW-1:0] MDU_MADDU = 4'd10;
  localparam logic [OPW-1:0] MDU_MSUB  = 4'd11;
  localparam logic [OPW-1:0] MDU_MSUBU = 4'd12;

  typedef enum logic {S_IDLE, S_RUN} mdu_state_t;

  // 64-bit product; operands are extended to 64 bits so the low 64 bits are exact either way.
  function automatic logic [2*XLEN-1:0] mul64(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic            sgn);
    logic [2*XLEN-1:0] ea;
    logic [2*XLEN-1:0] eb;
    ea = sgn ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = sgn ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed case works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 and quotient truncates toward zero.
  // A zero divisor is replaced by 1; the caller discards that result.
  function automatic logic [2*XLEN-1:0] div64(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic            sgn);
    logic [XLEN-1:0] ma;
    logic [XLEN-1:0] mb;
    logic [XLEN-1:0] uq;
    logic [XLEN-1:0] ur;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    ma = (sgn && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
    mb = (sgn && b[XLEN-1]) ? (~b + XLEN'(1)) : b;
    if (mb == '0) mb = XLEN'(1);
    uq = ma / mb;
    ur = ma % mb;
    q  = (sgn && (a[XLEN-1] ^ b[XLEN-1])) ? (~uq + XLEN'(1)) : uq;
    r  = (sgn && a[XLEN-1]) ? (~ur + XLEN'(1)) : ur;
    return {r, q};
  endfunction

endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu/msub/msubu).
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   A, B            rs/rt operands
//   MDUOp, Start    operation code, qualifier for write-type ops
//   Busy            high while a mult/div is in flight
//   HI, LO          architectural HI/LO
//   Result          combinational mfhi/mflo read data (0 otherwise)
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [OPW-1:0]  MDUOp,
  input  logic            Start,
  output logic            Busy,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAXC + 1);

  mdu_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] pend, pend_nx;
  logic              pwe, pwe_nx;

  // State, counter, HI/LO and pending result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      pend  <= '0;
      pwe   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      HI    <= hi_nx;
      LO    <= lo_nx;
      pend  <= pend_nx;
      pwe   <= pwe_nx;
    end
  end

  // Next-state: launch ops from IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = HI;
    lo_nx    = LO;
    pend_nx  = pend;
    pwe_nx   = pwe;
    case (state)
      S_IDLE: begin
        if (Start) begin
          case (MDUOp)
            MDU_MULT, MDU_MULTU: begin
              pend_nx  = mul64(A, B, MDUOp == MDU_MULT);
              pwe_nx   = 1'b1;
              cnt_nx   = CNT_W'(MULT_CYCLES);
              state_nx = S_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_nx  = div64(A, B, MDUOp == MDU_DIV);
              pwe_nx   = (B != '0);   // divide by zero leaves HI/LO untouched
              cnt_nx   = CNT_W'(DIV_CYCLES);
              state_nx = S_RUN;
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
              pend_nx  = {HI, LO} + mul64(A, B, MDUOp == MDU_MADD);
              pwe_nx   = 1'b1;
              cnt_nx   = CNT_W'(MULT_CYCLES);
              state_nx = S_RUN;
            end
            MDU_MSUB, MDU_MSUBU: begin
              pend_nx  = {HI, LO} - mul64(A, B, MDUOp == MDU_MSUB);
              pwe_nx   = 1'b1;
              cnt_nx   = CNT_W'(MULT_CYCLES);
              state_nx = S_RUN;
            end
`endif
            MDU_MTHI: hi_nx = A;
            MDU_MTLO: lo_nx = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = S_IDLE;
          if (pwe) begin
            hi_nx = pend[2*XLEN-1:XLEN];
            lo_nx = pend[XLEN-1:0];
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign Busy   = (state == S_RUN);
  assign Result = (MDUOp == MDU_MFHI) ? HI :
                  (MDUOp == MDU_MFLO) ? LO : '0;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
module tb_mdu;
  import mdu_pkg::*;

  logic            clk;
  logic            reset;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [OPW-1:0]  MDUOp;
  logic            Start;
  logic            Busy;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;
  logic [XLEN-1:0] Result;

  int total = 0;
  int bad   = 0;
  int n;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .MDUOp  (MDUOp),
    .Start  (Start),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents an op for one rising edge and returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
  endtask

  // Counts negedges (including the current one) at which Busy is high, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; MDUOp = MDU_NONE; Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    issue(MDU_MULT, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    chk("mult_cyc", 32'(n), 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    // Back-to-back: issued in the first idle cycle
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    chk("multu_cyc", 32'(n), 32'd5);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_cyc", 32'(n), 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'h0);

    issue(MDU_MTHI, 32'h12345678, 32'd0);
    chk("mthi_busy", 32'(Busy), 32'd0);
    chk("mthi_hi", HI, 32'h12345678);
    issue(MDU_MTLO, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);

    issue(MDU_DIVU, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_cyc", 32'(n), 32'd10);
    chk("div0_hi", HI, 32'h12345678);
    chk("div0_lo", LO, 32'h9ABCDEF0);

    MDUOp = MDU_MFHI; #1;
    chk("mfhi", Result, 32'h12345678);
    MDUOp = MDU_MFLO; #1;
    chk("mflo", Result, 32'h9ABCDEF0);
    MDUOp = MDU_NONE; #1;
    chk("res_none", Result, 32'h0);

    // Start with a read-type op changes nothing
    issue(MDU_MFHI, 32'hDEADBEEF, 32'd1);
    chk("mf_start_busy", 32'(Busy), 32'd0);
    chk("mf_start_hi", HI, 32'h12345678);

    // Start during RUN must be ignored
    issue(MDU_MULT, 32'd3, 32'd4);
    MDUOp = MDU_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
    wait_idle(n);
    chk("ign_cyc", 32'(1 + n), 32'd5);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'd12);
    @(negedge clk);
    @(negedge clk);
    chk("ign_busy", 32'(Busy), 32'd0);

    // Asynchronous reset mid-RUN
    issue(MDU_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; #1;
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(MDU_MULT, 32'd6, 32'd7);
    wait_idle(n);
    chk("post_rst_cyc", 32'(n), 32'd5);
    chk("post_rst_lo", LO, 32'd42);
    chk("post_rst_hi", HI, 32'd0);

`ifdef MDU_MADD_EN
    issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
    issue(MDU_MTHI, 32'h0, 32'd0);
    issue(MDU_MADDU, 32'd1, 32'd1);
    wait_idle(n);
    chk("maddu_cyc", 32'(n), 32'd5);
    chk("maddu_hi", HI, 32'd1);
    chk("maddu_lo", LO, 32'd0);
    issue(MDU_MSUB, 32'd2, 32'd3);
    wait_idle(n);
    chk("msub_hi", HI, 32'd0);
    chk("msub_lo", LO, 32'hFFFFFFFA);
`else
    // Madd-family encodings decode as no-op when the feature is absent
    issue(MDU_MADDU, 32'd1, 32'd1);
    chk("nomadd_busy", 32'(Busy), 32'd0);
    chk("nomadd_lo", LO, 32'd42);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
